mat_dma_master: RTL and testbench



---
 rtl/mat_dma_master.sv | 179 +++++++++++++++++
 tb/tb_mat_dma_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_dma_master.sv
// Bus master M1: loads A and B operands from memory into the multiplier's FIFOs, then writes the multiply kick.
// Latency: 3 cycles per element after a 1-cycle request; with constant grant, done is in cycle 51 after start.
// Backpressure: grant loss sends the block back to REQ and it retries the current element (or the kick); no push is repeated.
// Optional feature: MATDMA_WAIT_OPDONE_EN holds the block in FIN after the kick until op_done, so done marks multiply completion.
module mat_dma_master #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int A_BASE      = 32,
    parameter int B_BASE      = 64,
    parameter int FIFO_A_ADDR = 0,
    parameter int FIFO_B_ADDR = 1,
    parameter int START_ADDR  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op_done,
    input  logic              M1_grant,
    input  logic [DATA_W-1:0] M_din,
    output logic              M1_req,
    output logic              M1_wr,
    output logic [ADDR_W-1:0] M1_address,
    output logic [DATA_W-1:0] M1_dout,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD   = 3'd2,
        S_WAIT = 3'd3,
        S_WR   = 3'd4,
        S_KICK = 3'd5,
`ifdef MATDMA_WAIT_OPDONE_EN
        S_FIN  = 3'd6,
`endif
        S_DONE = 3'd7
    } state_t;

    state_t     state;
    logic [3:0] k;          // element index: 0..7 from A, 8..15 from B
    logic       kick_pend;  // set once all 16 pushes are done; a regrant resumes at KICK

`ifndef MATDMA_WAIT_OPDONE_EN
    logic unused_op_done;
    assign unused_op_done = op_done;
`endif

    // Source address for element kk: A walks 0,1,0,1,2,3,2,3 and B walks 0,2,1,3,0,2,1,3
    function automatic logic [ADDR_W-1:0] rd_addr(input logic [3:0] kk);
        logic [ADDR_W-1:0] off;
        off = '0;
        if (kk[3]) begin
            off[1:0] = {kk[0], kk[1]};
            rd_addr  = ADDR_W'(B_BASE) + off;
        end else begin
            off[1:0] = {kk[2], kk[0]};
            rd_addr  = ADDR_W'(A_BASE) + off;
        end
    endfunction

    // FIFO push target for element kk
    function automatic logic [ADDR_W-1:0] tgt_addr(input logic [3:0] kk);
        tgt_addr = kk[3] ? ADDR_W'(FIFO_B_ADDR) : ADDR_W'(FIFO_A_ADDR);
    endfunction

    // Control FSM; every bus output is registered alongside the state it belongs to
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            k          <= 4'd0;
            kick_pend  <= 1'b0;
            M1_req     <= 1'b0;
            M1_wr      <= 1'b0;
            M1_address <= '0;
            M1_dout    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_REQ;
                        k         <= 4'd0;
                        kick_pend <= 1'b0;
                        M1_req    <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (M1_grant) begin
                        if (kick_pend) begin
                            state      <= S_KICK;
                            M1_wr      <= 1'b1;
                            M1_address <= ADDR_W'(START_ADDR);
                            M1_dout    <= DATA_W'(1);
                        end else begin
                            state      <= S_RD;
                            M1_wr      <= 1'b0;
                            M1_address <= rd_addr(k);
                        end
                    end
                end
                S_RD: begin
                    state <= M1_grant ? S_WAIT : S_REQ;
                end
                S_WAIT: begin
                    // read data arrives one cycle after the address, so it is captured here, not in RD
                    if (!M1_grant) begin
                        state <= S_REQ;
                    end else begin
                        state      <= S_WR;
                        M1_wr      <= 1'b1;
                        M1_address <= tgt_addr(k);
                        M1_dout    <= M_din;
                    end
                end
                S_WR: begin
                    if (!M1_grant) begin
                        // push not accepted: re-read this element after regrant
                        state <= S_REQ;
                        M1_wr <= 1'b0;
                    end else if (k == 4'd15) begin
                        state      <= S_KICK;
                        kick_pend  <= 1'b1;
                        M1_address <= ADDR_W'(START_ADDR);
                        M1_dout    <= DATA_W'(1);
                    end else begin
                        state      <= S_RD;
                        k          <= k + 4'd1;
                        M1_wr      <= 1'b0;
                        M1_address <= rd_addr(k + 4'd1);
                    end
                end
                S_KICK: begin
                    if (!M1_grant) begin
                        state <= S_REQ;
                        M1_wr <= 1'b0;
                    end else begin
                        kick_pend <= 1'b0;
`ifdef MATDMA_WAIT_OPDONE_EN
                        state     <= S_FIN;
                        M1_wr     <= 1'b0;
`else
                        state      <= S_DONE;
                        M1_req     <= 1'b0;
                        M1_wr      <= 1'b0;
                        M1_address <= '0;
                        M1_dout    <= '0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
`endif
                    end
                end
`ifdef MATDMA_WAIT_OPDONE_EN
                S_FIN: begin
                    if (op_done) begin
                        state      <= S_DONE;
                        M1_req     <= 1'b0;
                        M1_address <= '0;
                        M1_dout    <= '0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mat_dma_master.sv
// Directed bench for mat_dma_master: memory model answers reads one cycle late, a monitor logs granted writes.
// Latency expectations are hand-derived cycle numbers counted from the edge that samples start (cycle 1 = REQ).
// Backpressure is exercised by dropping grant in the WAIT of element 5.
module tb_mat_dma_master;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
`ifdef MATDMA_WAIT_OPDONE_EN
    localparam int XTRA = 40;   // op_done comes 40 cycles after KICK, done follows one cycle later
`else
    localparam int XTRA = 0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              op_done = 1'b0;
    logic              M1_grant = 1'b1;
    logic [DATA_W-1:0] M_din = '0;
    logic              M1_req;
    logic              M1_wr;
    logic [ADDR_W-1:0] M1_address;
    logic [DATA_W-1:0] M1_dout;
    logic              busy;
    logic              done;

    mat_dma_master dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op_done    (op_done),
        .M1_grant   (M1_grant),
        .M_din      (M_din),
        .M1_req     (M1_req),
        .M1_wr      (M1_wr),
        .M1_address (M1_address),
        .M1_dout    (M1_dout),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory: A at 32..35 holds 10..13, B at 64..67 holds 14..17
    function automatic logic [DATA_W-1:0] mem(input logic [ADDR_W-1:0] a);
        if (a >= 8'd32 && a <= 8'd35) return DATA_W'(a - 8'd32) + 32'd10;
        if (a >= 8'd64 && a <= 8'd67) return DATA_W'(a - 8'd64) + 32'd14;
        return 32'hDEAD_BEEF;
    endfunction

    // read data valid one cycle after the address
    always @(posedge clk) M_din <= mem(M1_address);

    // monitor: granted writes and done pulses
    int          wa [64];
    int          wb [64];
    int          wa_n = 0, wb_n = 0;
    int          kick_cnt = 0, kick_cyc = 0;
    int          done_cnt = 0, done_cyc = 0;
    logic        done_busy = 1'b0, done_req_prev = 1'b0, req_prev = 1'b0;

    always @(negedge clk) begin
        if (M1_req && M1_grant && M1_wr) begin
            if (M1_address == 8'd0 && wa_n < 64) begin
                wa[wa_n] = int'(M1_dout);
                wa_n++;
            end else if (M1_address == 8'd1 && wb_n < 64) begin
                wb[wb_n] = int'(M1_dout);
                wb_n++;
            end else if (M1_address == 8'd3 && M1_dout == 32'd1) begin
                kick_cnt++;
                kick_cyc = cyc;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc      = cyc;
            done_busy     = busy;
            done_req_prev = req_prev;
        end
        req_prev = M1_req;
    end

    // multiplier model: one-cycle op_done 40 cycles after each kick (ignored without the macro)
    always @(posedge clk) begin
        #1;
        op_done = (kick_cnt != 0) && (cyc == kick_cyc + 40);
    end

    int vectors = 0;
    int miscompares = 0;
    int t0 = 0, base_a = 0, base_b = 0, base_k = 0, base_d = 0;
    int exp_a [8] = '{10, 11, 10, 11, 12, 13, 12, 13};
    int exp_b [8] = '{14, 16, 15, 17, 14, 16, 15, 17};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_req"},  64'(M1_req), 64'd0);
        check({tag, "_wr"},   64'(M1_wr), 64'd0);
        check({tag, "_addr"}, 64'(M1_address), 64'd0);
        check({tag, "_dout"}, 64'(M1_dout), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // pulse start; afterwards we are in cycle 1 and cycle n = cyc - t0 + 1
    task automatic run_start();
        start = 1'b1;
        tick();
        start  = 1'b0;
        t0     = cyc;
        base_a = wa_n;
        base_b = wb_n;
        base_k = kick_cnt;
        base_d = done_cnt;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cnt == base_d && n < 400) begin
            tick();
            n++;
        end
        tick();
        tick();
        check({tag, "_done_count"}, 64'(done_cnt - base_d), 64'd1);
    endtask

    task automatic check_run(input string tag, input int done_at);
        check({tag, "_a_count"}, 64'(wa_n - base_a), 64'd8);
        check({tag, "_b_count"}, 64'(wb_n - base_b), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_a%0d", tag, i), 64'(wa[base_a + i]), 64'(exp_a[i]));
            check($sformatf("%s_b%0d", tag, i), 64'(wb[base_b + i]), 64'(exp_b[i]));
        end
        check({tag, "_kicks"},     64'(kick_cnt - base_k), 64'd1);
        check({tag, "_done_cyc"},  64'(done_cyc - t0 + 1), 64'(done_at));
        check({tag, "_done_busy"}, 64'(done_busy), 64'd0);
        check({tag, "_req_before_done"}, 64'(done_req_prev), 64'd1);
        check_quiet({tag, "_idle"});
    endtask

    initial begin
        // reset state
        reset = 1'b1;
        tick();
        tick();
        check_quiet("reset");
        reset = 1'b0;
        tick();

        // run 1: constant grant, first-element timing then full streams
        run_start();
        check("r1_c1_req",  64'(M1_req), 64'd1);
        check("r1_c1_busy", 64'(busy), 64'd1);
        tick();
        check("r1_c2_rd_addr", 64'(M1_address), 64'd32);
        check("r1_c2_rd_wr",   64'(M1_wr), 64'd0);
        tick();
        check("r1_c3_wait_addr", 64'(M1_address), 64'd32);
        tick();
        check("r1_c4_wr_addr", 64'(M1_address), 64'd0);
        check("r1_c4_wr_wr",   64'(M1_wr), 64'd1);
        check("r1_c4_wr_dout", 64'(M1_dout), 64'd10);
        wait_done("r1");
        check_run("r1", 51 + XTRA);

        // run 2: a second start in cycle 20 is ignored
        run_start();
        repeat (19) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("r2");
        check_run("r2", 51 + XTRA);

        // run 3: grant lost in the WAIT of k=5 (cycle 18) through cycle 20
        run_start();
        repeat (17) tick();
        M1_grant = 1'b0;
        tick();
        tick();
        tick();
        M1_grant = 1'b1;
        tick();
        // cycle 22: re-issued read of element 5, A offset {k[2],k[0]} = 3
        check("r3_reread_addr", 64'(M1_address), 64'd35);
        check("r3_reread_wr",   64'(M1_wr), 64'd0);
        check("r3_reread_req",  64'(M1_req), 64'd1);
        wait_done("r3");
        check_run("r3", 56 + XTRA);

        // run 4: reset in cycle 30, then a clean restart from k=0
        run_start();
        repeat (29) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_quiet("r4_after_reset");
        tick();
        tick();
        check_quiet("r4_stays_idle");
        run_start();
        tick();
        check("r4_restart_addr", 64'(M1_address), 64'd32);
        check("r4_restart_wr",   64'(M1_wr), 64'd0);
        wait_done("r4");
        check_run("r4", 51 + XTRA);

        // reset and start together: reset wins
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check_quiet("reset_vs_start");
        tick();
        check("reset_vs_start_next_req", 64'(M1_req), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
